// File: rtl/ahblite_db_regbank.sv
// ahblite_db_regbank: AHB-lite slave exposing NREG debug registers of DW bits.
// Register i sits at byte offset 4*i. Writes may use byte, halfword or word
// lanes. Each register update raises a one-cycle notification pulse on the
// following cycle. Illegal transfers get the two-cycle AHB ERROR response.
// Optional feature: define DB_REGBANK_LOCK_EN to add a sticky write-lock
// register at offset 0x3C. Once it is set, writes to the debug registers are
// rejected. Only reset clears it.
//
// Handshake: a transfer is accepted in its address phase when
// HSEL & HREADY & HTRANS[1]. Its data phase is the following cycle. A legal
// data phase always completes with zero wait states (HREADYOUT=1, OKAY). An
// illegal one completes after ERR1 (HREADYOUT=0, ERROR) and then ERR2
// (HREADYOUT=1, ERROR).
module ahblite_db_regbank #(
  parameter int NREG = 4,
  parameter int DW   = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic                 HREADY,
  input  logic                 HWRITE,
  input  logic [23:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic [1:0]           HRESP,
  output logic [NREG*DW-1:0]   db_reg,
  output logic [NREG-1:0]      db_wr_pulse
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t state_q, state_d;

  logic          accept;
  logic          legal;
  logic          lock_eff;
  logic          dp_valid_q;
  logic          dp_write_q;
  logic [2:0]    dp_size_q;
  logic [5:0]    dp_addr_q;
  logic [3:0]    dp_idx;
  logic [3:0]    strb;
  logic [DW-1:0] wmask;
  logic [NREG-1:0] wr_en;
  logic [31:0]   rd_val;
  logic [DW-1:0] regs [NREG];
  logic          unused_ok;

  // Bits that carry no meaning for this slave are collected here.
  assign unused_ok = ^{HTRANS[0], HWDATA};

  // An accepted transfer needs a non-IDLE/BUSY type and a ready bus. ERR1 is
  // excluded in case a master ignores the stalled HREADY.
  assign accept = HSEL & HREADY & HTRANS[1] & (state_q != ST_ERR1);
  assign dp_idx = dp_addr_q[5:2];

  // Address-phase legality: size, alignment, offset range, and write lock.
  function automatic logic xfer_legal(input logic [23:0] a, input logic [2:0] sz,
                                      input logic wr, input logic lk);
    logic ok;
    ok = 1'b1;
    if (sz > 3'b010) ok = 1'b0;
    if (sz == 3'b001 && a[0]) ok = 1'b0;
    if (sz == 3'b010 && a[1:0] != 2'b00) ok = 1'b0;
    if (a[23:6] != '0) ok = 1'b0;
    if (int'(a[5:2]) >= NREG) begin
`ifdef DB_REGBANK_LOCK_EN
      if (a[5:2] != 4'hF) ok = 1'b0;
`else
      ok = 1'b0;
`endif
    end else if (wr && lk) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  assign legal = xfer_legal(HADDR, HSIZE, HWRITE, lock_eff);

  // Byte-lane strobes from the registered size and low address bits.
  always_comb begin
    strb = 4'b0000;
    case (dp_size_q)
      3'b000:  strb = 4'b0001 << dp_addr_q[1:0];
      3'b001:  strb = dp_addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Per-bit write mask. Lanes beyond DW simply have no bits.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW; b++) wmask[b] = strb[b / 8];
  end

  // One write enable per register during a legal write data phase.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NREG; i++)
      wr_en[i] = dp_valid_q & dp_write_q & (dp_idx == 4'(i));
  end

`ifdef DB_REGBANK_LOCK_EN
  logic lock_q;
  logic lock_set;
  // A lock write in the current data phase must already block a write in the
  // address phase that overlaps it.
  assign lock_set = dp_valid_q & dp_write_q & (dp_idx == 4'hF) & strb[0] & HWDATA[0];
  assign lock_eff = lock_q | lock_set;

  // Sticky lock bit, cleared only by reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) lock_q <= 1'b0;
    else          lock_q <= lock_q | lock_set;
  end
`else
  assign lock_eff = 1'b0;
`endif

  // Address-phase capture. Only legal transfers open a data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 3'b000;
      dp_addr_q  <= 6'd0;
    end else begin
      dp_valid_q <= accept & legal;
      if (accept) begin
        dp_write_q <= HWRITE;
        dp_size_q  <= HSIZE;
        dp_addr_q  <= HADDR[5:0];
      end
    end
  end

  // Register storage, updated at the end of a legal write data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (wr_en[i]) regs[i] <= (regs[i] & ~wmask) | (HWDATA[DW-1:0] & wmask);
    end
  end

  // Notification pulse in the cycle after each register update.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) db_wr_pulse <= '0;
    else          db_wr_pulse <= wr_en;
  end

  // Read mux: the selected register zero-extended to 32 bits.
  always_comb begin
    rd_val = 32'd0;
    for (int i = 0; i < NREG; i++)
      if (dp_idx == 4'(i)) rd_val[DW-1:0] = regs[i];
`ifdef DB_REGBANK_LOCK_EN
    if (dp_idx == 4'hF) rd_val = {31'd0, lock_q};
`endif
  end

  assign HRDATA = (dp_valid_q & ~dp_write_q) ? rd_val : 32'hDEADBEEF;

  // Flattened register view.
  always_comb begin
    db_reg = '0;
    for (int i = 0; i < NREG; i++) db_reg[i*DW +: DW] = regs[i];
  end

  // Error-response FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Error-response FSM next state and bus response outputs.
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    case (state_q)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = 2'b01;
        state_d = (accept && !legal) ? ST_ERR1 : ST_IDLE;
      end
      default: begin
        state_d = (accept && !legal) ? ST_ERR1 : ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ahblite_db_regbank.sv
// Directed bench for ahblite_db_regbank: one DW=4 instance and one DW=16
// instance share the bus inputs, and each instance's responses are checked.
module tb_ahblite_db_regbank;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic        hwrite;
  logic [23:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;

  logic [31:0] rdata4, rdata16;
  logic        rdy4, rdy16;
  logic [1:0]  resp4, resp16;
  logic [15:0] reg4;
  logic [63:0] reg16;
  logic [3:0]  pls4, pls16;

  int n_vec = 0;
  int n_err = 0;

  assign hready = rdy4;

  ahblite_db_regbank #(.NREG(4), .DW(4)) dut4 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HWRITE(hwrite),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(rdata4), .HREADYOUT(rdy4), .HRESP(resp4),
    .db_reg(reg4), .db_wr_pulse(pls4)
  );

  ahblite_db_regbank #(.NREG(4), .DW(16)) dut16 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel), .HREADY(hready), .HWRITE(hwrite),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(rdata16), .HREADYOUT(rdy16), .HRESP(resp16),
    .db_reg(reg16), .db_wr_pulse(pls16)
  );

  // Clock
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic [23:0] a, input logic w, input logic [2:0] sz);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 24'd0;
    hwrite = 1'b0;
    hsize  = 3'b000;
  endtask

  // Single write with no transfer overlapping it. Returns one cycle after the
  // commit, when the notification pulse is visible.
  task automatic do_write(input logic [23:0] a, input logic [2:0] sz, input logic [31:0] d);
    drive_addr(a, 1'b1, sz);
    tick();
    drive_idle();
    hwdata = d;
    tick();
  endtask

  // Illegal transfer: checks ERR1, ERR2 and the return to IDLE.
  task automatic err_seq(input string tag, input logic [23:0] a, input logic w,
                         input logic [2:0] sz);
    drive_addr(a, w, sz);
    tick();
    drive_idle();
    hwdata = 32'h0000FFFF;
    chk({tag, "_err1_rdy"}, {63'd0, rdy4}, 64'd0);
    chk({tag, "_err1_resp"}, {62'd0, resp4}, 64'd1);
    chk({tag, "_err1_rdata"}, {32'd0, rdata4}, 64'hDEADBEEF);
    tick();
    chk({tag, "_err2_rdy"}, {63'd0, rdy16}, 64'd1);
    chk({tag, "_err2_resp"}, {62'd0, resp16}, 64'd1);
    tick();
    chk({tag, "_idle_resp"}, {62'd0, resp4}, 64'd0);
    chk({tag, "_no_pulse"}, {56'd0, pls4, pls16}, 64'd0);
  endtask

  initial begin
    hresetn = 1'b0;
    hwdata  = 32'd0;
    drive_idle();

    // Reset state
    #3;
    chk("rst_rdy", {63'd0, rdy4}, 64'd1);
    chk("rst_resp", {62'd0, resp4}, 64'd0);
    chk("rst_rdata", {32'd0, rdata4}, 64'hDEADBEEF);
    chk("rst_reg4", {48'd0, reg4}, 64'd0);
    chk("rst_reg16", reg16, 64'd0);
    chk("rst_pulse", {56'd0, pls4, pls16}, 64'd0);
    tick();
    tick();
    hresetn = 1'b1;
    tick();
    chk("post_rst_rdy", {63'd0, rdy4}, 64'd1);

    // Word write 0xA to offset 0x8
    do_write(24'h8, 3'b010, 32'h0000000A);
    chk("w8_reg4", {48'd0, reg4}, 64'h0A00);
    chk("w8_reg16", reg16, 64'h0000_000A_0000_0000);
    chk("w8_pulse4", {60'd0, pls4}, 64'b0100);
    chk("w8_pulse16", {60'd0, pls16}, 64'b0100);
    tick();
    chk("w8_pulse_gone", {56'd0, pls4, pls16}, 64'd0);

    // Read back offset 0x8
    drive_addr(24'h8, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("r8_rdata4", {32'd0, rdata4}, 64'h0000000A);
    chk("r8_rdata16", {32'd0, rdata16}, 64'h0000000A);
    chk("r8_resp", {62'd0, resp4}, 64'd0);
    tick();
    chk("r8_rdata_idle", {32'd0, rdata4}, 64'hDEADBEEF);

    // Word write 0x1234 to reg0, then byte write lane 1 with 0xAB
    do_write(24'h0, 3'b010, 32'h00001234);
    do_write(24'h1, 3'b000, 32'h0000AB00);
    chk("byte_reg16", reg16, 64'h0000_000A_0000_AB34);
    chk("byte_reg4", {48'd0, reg4}, 64'h0A04);
    chk("byte_pulse", {60'd0, pls16}, 64'b0001);

    // Aligned halfword write to reg1
    do_write(24'h4, 3'b001, 32'h0000BEEF);
    chk("half_reg4", {48'd0, reg4}, 64'h0AF4);
    chk("half_reg16", reg16, 64'h0000_000A_BEEF_AB34);

    // Illegal transfers
    err_seq("mis_half", 24'h5, 1'b1, 3'b001);
    err_seq("oob_read", 24'h20, 1'b0, 3'b010);
    err_seq("big_size", 24'h0, 1'b1, 3'b011);
    err_seq("mis_word", 24'h2, 1'b1, 3'b010);
    err_seq("high_addr", 24'h100, 1'b1, 3'b010);
    chk("err_reg4", {48'd0, reg4}, 64'h0AF4);
    chk("err_reg16", reg16, 64'h0000_000A_BEEF_AB34);

    // Back-to-back writes to reg0 and reg3
    drive_addr(24'h0, 1'b1, 3'b010);
    tick();
    hwdata = 32'h00000001;
    drive_addr(24'hC, 1'b1, 3'b010);
    tick();
    drive_idle();
    hwdata = 32'h00000007;
    chk("b2b_pulse_a", {60'd0, pls4}, 64'b0001);
    tick();
    chk("b2b_pulse_b", {60'd0, pls4}, 64'b1000);
    chk("b2b_reg4", {48'd0, reg4}, 64'h7AF1);
    chk("b2b_reg16", reg16, 64'h0007_000A_BEEF_0001);
    tick();
    chk("b2b_pulse_end", {60'd0, pls4}, 64'd0);

    // Write to reg1 immediately followed by a read of reg1
    drive_addr(24'h4, 1'b1, 3'b010);
    tick();
    hwdata = 32'h00000003;
    drive_addr(24'h4, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("raw_rdata4", {32'd0, rdata4}, 64'h3);
    chk("raw_rdata16", {32'd0, rdata16}, 64'h3);
    tick();

    // New address phase presented during ERR2
    drive_addr(24'h20, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("err2acc_err1", {63'd0, rdy4}, 64'd0);
    tick();
    drive_addr(24'h8, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("err2acc_rdata", {32'd0, rdata4}, 64'hA);
    chk("err2acc_resp", {62'd0, resp4}, 64'd0);
    tick();

    // BUSY transfer while selected has no effect
    hsel = 1'b1;
    htrans = 2'b01;
    haddr = 24'h0;
    hwrite = 1'b1;
    hsize = 3'b010;
    tick();
    drive_idle();
    hwdata = 32'h0000000F;
    tick();
    chk("busy_reg4", {48'd0, reg4}, 64'h7A31);
    chk("busy_pulse", {56'd0, pls4, pls16}, 64'd0);

`ifdef DB_REGBANK_LOCK_EN
    // Lock, then a blocked write, then the lock readback
    do_write(24'h3C, 3'b010, 32'h00000001);
    err_seq("locked_wr", 24'h0, 1'b1, 3'b010);
    chk("locked_reg4", {48'd0, reg4}, 64'h7A31);
    drive_addr(24'h3C, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("lock_rd", {32'd0, rdata4}, 64'h1);
    tick();
    hresetn = 1'b0;
    tick();
    hresetn = 1'b1;
    tick();
    drive_addr(24'h3C, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("lock_rd_after_rst", {32'd0, rdata4}, 64'h0);
    tick();
    do_write(24'h0, 3'b010, 32'h0000000F);
    chk("unlocked_wr", {60'd0, reg4[3:0]}, 64'hF);
`else
    err_seq("lock_off_3c", 24'h3C, 1'b1, 3'b010);
    chk("lock_off_reg4", {48'd0, reg4}, 64'h7A31);
`endif

    // Reset asserted during ERR1
    drive_addr(24'h20, 1'b0, 3'b010);
    tick();
    drive_idle();
    chk("rst_err1_pre", {63'd0, rdy4}, 64'd0);
    hresetn = 1'b0;
    #1;
    chk("rst_err1_rdy", {63'd0, rdy4}, 64'd1);
    chk("rst_err1_resp", {62'd0, resp4}, 64'd0);
    chk("rst_err1_reg4", {48'd0, reg4}, 64'd0);
    chk("rst_err1_reg16", reg16, 64'd0);
    tick();
    hresetn = 1'b1;
    tick();
    chk("rst_err1_after", {62'd0, resp16}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahblite_db_regbank.md
AHBLITE_DB_REGBANK -- requirements
Module: ahblite_db_regbank

Interface
REQ-001 SHALL have parameter NREG, default 4, number of debug registers (legal 1..15).
REQ-002 SHALL have parameter DW, default 4, width of each debug register (legal 1..32).
REQ-003 SHALL have port HCLK  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports HSEL, HREADY, HWRITE  input  1 each  AHB-lite select, bus ready, write control.
REQ-006 SHALL have port HADDR  input  24  byte address; bits [1:0] used for byte lanes.
REQ-007 SHALL have ports HTRANS  input  2, HSIZE  input  3, HWDATA  input  32  AHB transfer type, size, write data.
REQ-008 SHALL have ports HRDATA  output  32, HREADYOUT  output  1, HRESP  output  2  AHB read data, ready, response.
REQ-009 SHALL have port db_reg  output  NREG*DW  register i on bits [i*DW+DW-1 : i*DW].
REQ-010 SHALL have port db_wr_pulse  output  NREG  per-register one-cycle write notification.

Function
REQ-011 SHALL accept a transfer (address phase) when HSEL & HREADY & HTRANS[1]; IDLE/BUSY or unselected cycles produce no data phase and an OKAY zero-wait response.
REQ-012 SHALL register HADDR, HWRITE, HSIZE only on an accepted transfer.
REQ-013 SHALL map register i at byte offset 4*i; offsets 4*NREG..0x3B, offset 0x3C when the lock feature is absent, any offset >= 0x40, and HSIZE > 3'b010 are illegal.
REQ-014 SHALL derive byte strobes from registered HSIZE and HADDR[1:0] (byte: 1 lane, halfword: 2 aligned lanes, word: 4 lanes); misaligned halfword/word transfers are illegal.
REQ-015 SHALL, on a legal write data phase, update only strobed bits of register i from HWDATA[DW-1:0] at the end of that cycle; bits >= DW are discarded.
REQ-016 SHALL assert db_wr_pulse[i] for exactly one cycle, the cycle after the update of register i; back-to-back writes produce back-to-back pulses.
REQ-017 SHALL, on a legal read data phase, drive HRDATA = register value zero-extended to 32 bits in the same cycle (zero wait states), OKAY response.
REQ-018 SHALL drive HRDATA = 32'hDEADBEEF whenever no legal read data phase is active.
REQ-019 SHALL respond to an illegal transfer with the two-cycle ERROR response via FSM IDLE -> ERR1 -> ERR2 -> IDLE: ERR1 HREADYOUT=0 HRESP=2'b01; ERR2 HREADYOUT=1 HRESP=2'b01; IDLE HREADYOUT=1 HRESP=2'b00.
REQ-020 SHALL leave all registers unchanged on an illegal write; no db_wr_pulse.
REQ-021 SHALL, in ERR2, accept a new address phase normally if presented (HREADY high); in ERR1 HREADY is low so no transfer is accepted.
REQ-022 SHALL treat a read-after-write to the same register as returning the new value (write committed before next data phase).

Reset
REQ-023 SHALL, on HRESETn low, asynchronously clear all db_reg bits, db_wr_pulse, lock bit, registered address-phase state, and return FSM to IDLE.
REQ-024 SHALL hold HREADYOUT=1, HRESP=2'b00 during and immediately after reset; reset during ERR1/ERR2 or mid-write aborts the transfer with no register update.

Configuration
REQ-025 SHALL compile the write-lock feature only when macro DB_REGBANK_LOCK_EN is defined.
REQ-026 SHALL, with DB_REGBANK_LOCK_EN, provide a lock register at offset 0x3C: bit0 set by writing 1, cleared only by reset, reads {31'd0,lock}; while lock=1 any write to register i is illegal (ERROR, no update).
REQ-027 SHALL, without DB_REGBANK_LOCK_EN, have no lock state; offset 0x3C is illegal and writes are never blocked.

Verification
REQ-028 SHALL cover: NREG=4, DW=4, word write 0x0000000A to offset 0x8 -> db_reg[11:8]=4'hA, db_wr_pulse=4'b0100 for one cycle, read returns 0x0000000A.
REQ-029 SHALL cover: DW=16, byte write 0x0000AB00 with HSIZE=0, HADDR[1:0]=1 to register 0 holding 0x1234 -> register 0 = 0xAB34.
REQ-030 SHALL cover: read offset 0x20 with NREG=4 -> ERR1 (HREADYOUT=0, HRESP=01), ERR2 (HREADYOUT=1, HRESP=01), HRDATA=0xDEADBEEF, no state change.
REQ-031 SHALL cover: halfword write at HADDR[1:0]=1 -> ERROR response, register unchanged.
REQ-032 SHALL cover (DB_REGBANK_LOCK_EN): write 1 to 0x3C, then write 0xF to offset 0x0 -> ERROR, db_reg[3:0] unchanged, read 0x3C = 0x00000001 until HRESETn pulse.
REQ-033 SHALL cover: HRESETn asserted during ERR1 -> HREADYOUT=1, HRESP=00, all db_reg=0 immediately.
